// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants, ALU control encoding and the per-stage control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int OP_W      = 6;
  localparam int FUNCT_W   = 6;
  localparam int ALU_ENC_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // Upper two bits of the ALU control word select funct-driven vs opcode-driven operation.
  localparam logic [1:0] ALU_SEL_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SEL_OP    = 2'b00;

  // Control bundle carried down the pipeline; valid=0 marks a bubble.
  typedef struct packed {
    logic                 valid;
    logic                 invalid;
    logic                 regwrite;
    logic                 regdst;
    logic                 memen;
    logic                 memwrite;
    logic                 memtoreg;
    logic                 alusrc;
    logic [ALU_ENC_W-1:0] aluctl;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [ALU_ENC_W-1:0] alu_encode(input logic [OP_W-1:0] op,
                                                      input logic [FUNCT_W-1:0] funct);
    if (op == OP_RTYPE) return {ALU_SEL_RTYPE, funct};
    return {ALU_SEL_OP, op};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode plus branch-condition evaluation for the D stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs, everything forced to bubble when valid_i=0.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  input  logic [DW-1:0]     compa_i,
  input  logic [DW-1:0]     compb_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        pcsrc_o
);

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  ctrl_t              c;
  logic               branch;
  logic               jump;
  logic               cond;
  logic               unused_instr;

  assign op           = instr_i[31:26];
  assign funct        = instr_i[5:0];
  // Register specifiers and immediates are not needed for control.
  assign unused_instr = ^instr_i[25:6];

  // Opcode decode; unrecognised opcodes flag invalid and leave every enable low.
  always_comb begin
    c      = CTRL_BUBBLE;
    branch = 1'b0;
    jump   = 1'b0;
    if (valid_i) begin
      c.valid  = 1'b1;
      c.aluctl = alu_encode(op, funct);
      case (op)
        OP_RTYPE: begin
          c.regwrite = 1'b1;
          c.regdst   = 1'b1;
        end
        OP_LW: begin
          c.memen    = 1'b1;
          c.memtoreg = 1'b1;
          c.regwrite = 1'b1;
          c.alusrc   = 1'b1;
        end
        OP_SW: begin
          c.memen    = 1'b1;
          c.memwrite = 1'b1;
          c.alusrc   = 1'b1;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
          c.regwrite = 1'b1;
          c.alusrc   = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: branch = 1'b1;
        OP_J:                             jump   = 1'b1;
        OP_JAL: begin
          jump       = 1'b1;
          c.regwrite = 1'b1;
        end
        default: c.invalid = 1'b1;
      endcase
    end
  end

  // Branch condition on the forwarded operands; blez/bgtz treat compa as signed.
  always_comb begin
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = (compa_i == compb_i);
      OP_BNE:  cond = (compa_i != compb_i);
      OP_BLEZ: cond = compa_i[DW-1] | (compa_i == '0);
      OP_BGTZ: cond = ~compa_i[DW-1] & (compa_i != '0);
      default: cond = 1'b0;
    endcase
  end

  assign ctrl_o  = c;
  assign pcsrc_o = {jump, branch & cond};

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control path: decode in D, then control bundle through E, M1..M(NMEM), W.
// Latency: D to W is NMEM+2 cycles without stalls; pcsrcD is combinational.
// Backpressure: stallE holds E and bubbles M1; flushE/flushM insert bubbles (flushE beats stallE).
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ALUCW = 8,   // must be >= ALU_ENC_W
  parameter int NMEM  = 1    // 1..3 memory stages
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      instrD,
  input  logic             validD,
  input  logic [DW-1:0]    compa,
  input  logic [DW-1:0]    compb,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             flushM,
  output logic [1:0]       pcsrcD,
  output logic [ALUCW-1:0] alucontrolE,
  output logic             alusrcE,
  output logic             regdstE,
  output logic             memenM,
  output logic             memwriteM,
  output logic             memtoregM,
  output logic             regwriteM,
  output logic             regwriteW,
  output logic             memtoregW,
  output logic             invalidE,
  output logic             busyE,
  output logic             busyM
);

  logic [CTRL_W-1:0] dec_ctrl;
  ctrl_t             dec_c;
  ctrl_t             e_d;
  ctrl_t             e_q;
  ctrl_t             m1_d;
  ctrl_t             m_out [NMEM];
  ctrl_t             m_last;
  logic [NMEM-1:0]   m_vld;
  logic              w_vld_q;
  logic              w_regwrite_q;
  logic              w_memtoreg_q;
  logic              unused_mlast;

  ctrl_decode #(
    .DW (DW)
  ) u_decode (
    .instr_i (instrD),
    .valid_i (validD),
    .compa_i (compa),
    .compb_i (compb),
    .ctrl_o  (dec_ctrl),
    .pcsrc_o (pcsrcD)
  );

  assign dec_c = ctrl_t'(dec_ctrl);

  // E next state: flush wins over stall, stall recirculates, otherwise take decode.
  always_comb begin
    e_d = dec_c;
    if (flushE)      e_d = CTRL_BUBBLE;
    else if (stallE) e_d = e_q;
  end

  // E register; reset discards anything held by a stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) e_q <= CTRL_BUBBLE;
    else         e_q <= e_d;
  end

  // M1 next state: bubble on flushM, on a real stall, or when E holds an invalid op.
  always_comb begin
    m1_d = e_q;
    if (flushM || (stallE && !flushE) || e_q.invalid) m1_d = CTRL_BUBBLE;
  end

  for (genvar g = 0; g < NMEM; g++) begin : g_mem
    ctrl_t stage_d;
    ctrl_t stage_q;
    if (g == 0) begin : g_first
      assign stage_d = m1_d;
    end else begin : g_rest
      assign stage_d = m_out[g-1];
    end
    // One memory-stage register; later stages always advance.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) stage_q <= CTRL_BUBBLE;
      else         stage_q <= stage_d;
    end
    assign m_out[g] = stage_q;
    assign m_vld[g] = stage_q.valid;
  end

  assign m_last = m_out[NMEM-1];
  // Execute-only fields are dead once the bundle reaches the last M stage.
  assign unused_mlast = ^{m_last.invalid, m_last.regdst, m_last.alusrc, m_last.aluctl};

  // Writeback register keeps only what W needs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_vld_q      <= 1'b0;
      w_regwrite_q <= 1'b0;
      w_memtoreg_q <= 1'b0;
    end else begin
      w_vld_q      <= m_last.valid;
      w_regwrite_q <= m_last.regwrite;
      w_memtoreg_q <= m_last.memtoreg;
    end
  end

  assign alucontrolE = ALUCW'(e_q.aluctl);
  assign alusrcE     = e_q.valid & e_q.alusrc;
  assign regdstE     = e_q.valid & e_q.regdst;
  assign invalidE    = e_q.valid & e_q.invalid;
  assign busyE       = e_q.valid;

  assign memenM      = m_last.valid & m_last.memen;
  assign memwriteM   = m_last.valid & m_last.memwrite;
  assign memtoregM   = m_last.valid & m_last.memtoreg;
  assign regwriteM   = m_last.valid & m_last.regwrite;
  assign busyM       = |m_vld;

  assign regwriteW   = w_vld_q & w_regwrite_q;
  assign memtoregW   = w_vld_q & w_memtoreg_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: NMEM=1 instance for most checks, NMEM=3 for reset/latency.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_controller;

  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_BNE  = 32'h1422_0003;
  localparam logic [31:0] I_BLEZ = 32'h1820_0003;
  localparam logic [31:0] I_BGTZ = 32'h1C20_0003;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;
  localparam logic [31:0] I_OP0E = 32'h3800_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] instrD;
  logic        validD;
  logic [31:0] compa, compb;
  logic        stallE, flushE, flushM;

  logic [1:0] pcsrcD, pcsrcD3;
  logic [7:0] alucontrolE, alucontrolE3;
  logic alusrcE, regdstE, memenM, memwriteM, memtoregM, regwriteM;
  logic regwriteW, memtoregW, invalidE, busyE, busyM;
  logic alusrcE3, regdstE3, memenM3, memwriteM3, memtoregM3, regwriteM3;
  logic regwriteW3, memtoregW3, invalidE3, busyE3, busyM3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_controller #(.DW(32), .ALUCW(8), .NMEM(1)) dut (
    .clk(clk), .resetn(resetn), .instrD(instrD), .validD(validD),
    .compa(compa), .compb(compb), .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .pcsrcD(pcsrcD), .alucontrolE(alucontrolE), .alusrcE(alusrcE), .regdstE(regdstE),
    .memenM(memenM), .memwriteM(memwriteM), .memtoregM(memtoregM), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregW(memtoregW), .invalidE(invalidE),
    .busyE(busyE), .busyM(busyM)
  );

  pipe_controller #(.DW(32), .ALUCW(8), .NMEM(3)) dut3 (
    .clk(clk), .resetn(resetn), .instrD(instrD), .validD(validD),
    .compa(compa), .compb(compb), .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .pcsrcD(pcsrcD3), .alucontrolE(alucontrolE3), .alusrcE(alusrcE3), .regdstE(regdstE3),
    .memenM(memenM3), .memwriteM(memwriteM3), .memtoregM(memtoregM3), .regwriteM(regwriteM3),
    .regwriteW(regwriteW3), .memtoregW(memtoregW3), .invalidE(invalidE3),
    .busyE(busyE3), .busyM(busyM3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // pcsrcD vectors: instruction, compa, compb, validD, expected {jump, taken}
  logic [31:0] pv_instr [8] = '{I_BEQ, I_BNE, I_BGTZ, I_BGTZ, I_BLEZ, I_JAL, I_BEQ, I_J};
  logic [31:0] pv_a     [8] = '{32'd5, 32'd5, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 32'd5, 32'd0};
  logic [31:0] pv_b     [8] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0};
  logic        pv_v     [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0]  pv_exp   [8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10};

  initial begin
    resetn = 1'b0; instrD = '0; validD = 1'b0; compa = '0; compb = '0;
    stallE = 1'b0; flushE = 1'b0; flushM = 1'b0;

    // Reset state
    #2;
    check("rst_busyE", busyE, 0);
    check("rst_busyM", busyM, 0);
    check("rst_aluctl", alucontrolE, 0);
    check("rst_regwriteW", regwriteW, 0);
    check("rst_busyM3", busyM3, 0);

    // lw through NMEM=1, first edge after release loads E
    @(negedge clk); resetn = 1'b1; instrD = I_LW; validD = 1'b1;
    @(negedge clk); validD = 1'b0; instrD = '0;
    check("lw_E_alusrc", alusrcE, 1);
    check("lw_E_aluctl", alucontrolE, 32'h23);
    check("lw_E_regwriteM", regwriteM, 0);
    @(negedge clk);
    check("lw_M_memen", memenM, 1);
    check("lw_M_memtoreg", memtoregM, 1);
    check("lw_M_regwrite", regwriteM, 1);
    check("lw_M_alusrcE", alusrcE, 0);
    @(negedge clk);
    check("lw_W_regwrite", regwriteW, 1);
    check("lw_W_memtoreg", memtoregW, 1);
    check("lw_W_regwriteM", regwriteM, 0);

    // Branch / jump resolution in D
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instrD = pv_instr[i]; compa = pv_a[i]; compb = pv_b[i]; validD = pv_v[i];
      #1;
      check($sformatf("pcsrc%0d", i), pcsrcD, pv_exp[i]);
    end
    @(negedge clk); validD = 1'b0; instrD = '0; compa = '0; compb = '0;
    repeat (4) @(negedge clk);

    // Stall: add in E held two cycles while sw waits in D
    instrD = I_ADD; validD = 1'b1;
    @(negedge clk);
    check("stl_E_regdst", regdstE, 1);
    check("stl_E_aluctl", alucontrolE, 32'hA0);
    instrD = I_SW; stallE = 1'b1;
    @(negedge clk);
    check("stl1_aluctl", alucontrolE, 32'hA0);
    check("stl1_memwriteM", memwriteM, 0);
    check("stl1_regwriteM", regwriteM, 0);
    @(negedge clk);
    check("stl2_aluctl", alucontrolE, 32'hA0);
    check("stl2_memwriteM", memwriteM, 0);
    check("stl2_busyM", busyM, 0);
    stallE = 1'b0;
    @(negedge clk);
    check("sw_E_aluctl", alucontrolE, 32'h2B);
    check("sw_E_alusrc", alusrcE, 1);
    check("add_M_regwrite", regwriteM, 1);
    check("add_M_memwrite", memwriteM, 0);
    validD = 1'b0; instrD = '0;
    @(negedge clk);
    check("sw_M_memwrite", memwriteM, 1);
    check("sw_M_memen", memenM, 1);
    check("sw_M_busyE", busyE, 0);
    @(negedge clk);
    check("sw_once", memwriteM, 0);
    repeat (2) @(negedge clk);

    // Invalid opcode 0x3F
    instrD = I_BAD; validD = 1'b1;
    @(negedge clk);
    check("bad_invalidE", invalidE, 1);
    check("bad_busyE", busyE, 1);
    check("bad_alusrcE", alusrcE, 0);
    validD = 1'b0; instrD = '0;
    @(negedge clk);
    check("bad_gone", invalidE, 0);
    check("bad_regwriteM", regwriteM, 0);
    check("bad_memenM", memenM, 0);
    check("bad_busyM", busyM, 0);
    @(negedge clk);
    check("bad_regwriteW", regwriteW, 0);
    // Opcode 0x0E is outside the immediate group
    instrD = I_OP0E; validD = 1'b1;
    @(negedge clk);
    check("op0e_invalidE", invalidE, 1);
    validD = 1'b0; instrD = '0;
    repeat (3) @(negedge clk);

    // flushE + stallE with add in D and empty E
    instrD = I_ADD; validD = 1'b1; flushE = 1'b1; stallE = 1'b1;
    @(negedge clk);
    check("fls_busyE", busyE, 0);
    check("fls_aluctl", alucontrolE, 0);
    check("fls_regdstE", regdstE, 0);
    flushE = 1'b0; stallE = 1'b0;
    // flushE + stallE with add already in E: E bubbles, add still advances to M
    @(negedge clk);
    check("fls2_busyE", busyE, 1);
    validD = 1'b0; flushE = 1'b1; stallE = 1'b1;
    @(negedge clk);
    check("fls2_busyE_after", busyE, 0);
    check("fls2_regwriteM", regwriteM, 1);
    flushE = 1'b0; stallE = 1'b0;
    repeat (3) @(negedge clk);

    // flushM drops the bundle leaving E
    instrD = I_ADD; validD = 1'b1;
    @(negedge clk);
    check("flm_regdstE", regdstE, 1);
    validD = 1'b0; flushM = 1'b1;
    @(negedge clk);
    check("flm_busyM", busyM, 0);
    check("flm_regwriteM", regwriteM, 0);
    flushM = 1'b0;
    @(negedge clk);
    check("flm_regwriteW", regwriteW, 0);
    repeat (2) @(negedge clk);

    // NMEM=3 lw stream, async reset mid-stream and mid-stall
    instrD = I_LW; validD = 1'b1;
    repeat (4) @(negedge clk);
    check("s3_pre_regwriteM", regwriteM3, 1);
    check("s3_pre_busyM", busyM3, 1);
    stallE = 1'b1;
    @(negedge clk);
    check("s1_held_busyE", busyE, 1);
    #2 resetn = 1'b0;
    #1;
    check("s3_rst_regwriteM", regwriteM3, 0);
    check("s3_rst_memenM", memenM3, 0);
    check("s3_rst_busyE", busyE3, 0);
    check("s3_rst_busyM", busyM3, 0);
    check("s3_rst_alusrcE", alusrcE3, 0);
    check("s3_rst_aluctl", alucontrolE3, 0);
    check("s3_rst_regwriteW", regwriteW3, 0);
    check("s3_rst_memtoregW", memtoregW3, 0);
    check("s1_rst_busyE", busyE, 0);
    instrD = I_JAL;
    #1;
    check("s3_rst_pcsrc", pcsrcD3, 2);
    instrD = I_LW;
    @(negedge clk); stallE = 1'b0;
    @(negedge clk); resetn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("s3_lat%0d_regwriteW", i), regwriteW3, (i == 5) ? 32'd1 : 32'd0);
      if (i == 1) begin
        check("s1_post_busyE", busyE, 1);
        check("s1_post_alusrcE", alusrcE, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
